// File: rtl/apb_completer_pkg.sv
// Shared types and access-decode helpers for the APB completer register file.
// Helpers are pure functions so the bridge can reuse the same decode rules.
package apb_completer_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned ID_IDX   = 0;
  localparam int unsigned ADDR_MAX = 64;

  function automatic logic [ADDR_MAX-1:0] addr_to_index(
    input logic [ADDR_MAX-1:0] addr,
    input int unsigned         lg
  );
    return addr >> lg;
  endfunction

  function automatic logic check_access(
    input logic [ADDR_MAX-1:0] addr,
    input logic                wr,
    input logic [2:0]          prot,
    input int unsigned         num_regs,
    input int unsigned         lg,
    input logic                priv_write
  );
    logic [ADDR_MAX-1:0] idx;
    logic [ADDR_MAX-1:0] mask;
    logic                err;
    idx  = addr_to_index(addr, lg);
    mask = (ADDR_MAX'(1) << lg) - ADDR_MAX'(1);
    err  = 1'b0;
    if (idx >= ADDR_MAX'(num_regs))               err = 1'b1;
    if ((addr & mask) != '0)                      err = 1'b1;
    if (wr && (idx == ADDR_MAX'(ID_IDX)))         err = 1'b1;
    if (wr && priv_write && !prot[0])             err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-strobe merge of write data into an existing word; purely combinational.
// No state and no flow control: output follows inputs in the same cycle.
module apb_strb_merge #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0]   old_dat,
  input  logic [DATAWIDTH-1:0]   new_dat,
  input  logic [DATAWIDTH/8-1:0] strb,
  output logic [DATAWIDTH-1:0]   merged_dat
);

  always_comb begin
    merged_dat = old_dat;
    for (int unsigned i = 0; i < DATAWIDTH/8; i++) begin
      if (strb[i]) merged_dat[i*8 +: 8] = new_dat[i*8 +: 8];
    end
  end

endmodule

// File: rtl/apb_completer_regfile.sv
// APB4 completer with an ID register, R/W registers, wait states and pslverr.
// Response is registered; pready pulses for one cycle WAIT_CYCLES+1 access cycles in.
module apb_completer_regfile
  import apb_completer_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned ADDRWIDTH   = 32,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001,
  parameter bit          PRIV_WRITE  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pselx,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDRWIDTH-1:0]          paddr,
  input  logic [DATAWIDTH-1:0]          pwdata,
  input  logic [DATAWIDTH/8-1:0]        pstrb,
  input  logic [2:0]                    pprot,
  output logic [DATAWIDTH-1:0]          prdata,
  output logic                          pready,
  output logic                          pslverr,
  output logic [NUM_REGS*DATAWIDTH-1:0] regs_o
);

  localparam int unsigned          STRBW  = DATAWIDTH / 8;
  localparam int unsigned          LG     = $clog2(STRBW);
  localparam int unsigned          IDXW   = $clog2(NUM_REGS);
  localparam logic [DATAWIDTH-1:0] ID_EXT = DATAWIDTH'(ID_VALUE);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [DATAWIDTH-1:0]  wdat_q, wdat_d;
  logic [STRBW-1:0]      strb_q, strb_d;
  logic                  err_q, err_d;
  logic [DATAWIDTH-1:0]  rsp_q, rsp_d;
  logic [DATAWIDTH-1:0]  prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATAWIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATAWIDTH-1:0]  regs_d [NUM_REGS];

  logic [IDXW-1:0]       setup_idx;
  logic                  setup_err;
  logic [DATAWIDTH-1:0]  setup_rsp;
  logic [DATAWIDTH-1:0]  merged_dat;

  // Register 0 holds ID_EXT as a constant, so reads need no special case.
  assign setup_idx = IDXW'(addr_to_index(ADDR_MAX'(paddr), LG));
  assign setup_err = check_access(ADDR_MAX'(paddr), pwrite, pprot, NUM_REGS, LG, PRIV_WRITE);
  assign setup_rsp = (setup_err || pwrite) ? '0 : regs_q[setup_idx];

  apb_strb_merge #(.DATAWIDTH(DATAWIDTH)) u_strb_merge (
    .old_dat    (regs_q[idx_q]),
    .new_dat    (wdat_q),
    .strb       (strb_q),
    .merged_dat (merged_dat)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wdat_d    = wdat_q;
    strb_d    = strb_q;
    err_d     = err_q;
    rsp_d     = rsp_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    regs_d    = regs_q;

    case (state_q)
      IDLE: begin
        if (pselx && !penable) begin
          idx_d  = setup_idx;
          wr_d   = pwrite;
          wdat_d = pwdata;
          strb_d = pstrb;
          err_d  = setup_err;
          rsp_d  = setup_rsp;
          if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = setup_rsp;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!pselx) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          prdata_d  = rsp_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (pselx && penable && wr_q && !err_q) regs_d[idx_q] = merged_dat;
      end
      default: state_d = IDLE;
    endcase

    regs_d[ID_IDX] = ID_EXT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdat_q    <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      rsp_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= (k == ID_IDX) ? ID_EXT : '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      wdat_q    <= wdat_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      rsp_q     <= rsp_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[k*DATAWIDTH +: DATAWIDTH] = regs_q[k];
  end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Scoreboard bench: two completers (0 and 3 wait states) against an array model.
module tb_apb_completer_regfile;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        clk;
  logic        rst;
  logic        psel_a   [2];
  logic        pen_a    [2];
  logic        pwr_a    [2];
  logic [31:0] paddr_a  [2];
  logic [31:0] pwdata_a [2];
  logic [3:0]  pstrb_a  [2];
  logic [2:0]  pprot_a  [2];
  logic [31:0] prdata_a [2];
  logic        pready_a [2];
  logic        pslverr_a[2];
  logic [255:0] regs_a  [2];

  int tests = 0;
  int fails = 0;

  logic [31:0] mregs [2][8];
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  bit          prev_rdy [2];

  apb_completer_regfile #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .pselx(psel_a[0]), .penable(pen_a[0]), .pwrite(pwr_a[0]),
    .paddr(paddr_a[0]), .pwdata(pwdata_a[0]), .pstrb(pstrb_a[0]), .pprot(pprot_a[0]),
    .prdata(prdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0]), .regs_o(regs_a[0])
  );

  apb_completer_regfile #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .pselx(psel_a[1]), .penable(pen_a[1]), .pwrite(pwr_a[1]),
    .paddr(paddr_a[1]), .pwdata(pwdata_a[1]), .pstrb(pstrb_a[1]), .pprot(pprot_a[1]),
    .prdata(prdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1]), .regs_o(regs_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] addr, input bit wr, input logic [2:0] prot);
    int unsigned idx = addr / 4;
    return (idx >= 8) || (addr % 4 != 0) || (wr && idx == 0) || (wr && !prot[0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mregs[i][0] = ID;
      for (int k = 1; k < 8; k++) mregs[i][k] = '0;
    end
  endtask

  task automatic chk_regs(input int d);
    for (int k = 1; k < 8; k++) chk($sformatf("regs_o[%0d] inst%0d", k, d), regs_a[d][k*32 +: 32], mregs[d][k]);
  endtask

  task automatic chk_quiet(input int d, input string nm);
    chk({nm, " pready"},  32'(pready_a[d]),  32'd0);
    chk({nm, " pslverr"}, 32'(pslverr_a[d]), 32'd0);
    chk({nm, " prdata"},  prdata_a[d],       32'd0);
  endtask

  // Leaves pselx/penable asserted so the caller may start a back-to-back setup.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] dat,
                      input logic [3:0] strb, input logic [2:0] prot);
    bit          err;
    logic [31:0] exp_d;
    int          n;
    bit          seen;
    int unsigned idx;
    idx   = addr / 4;
    err   = model_err(addr, wr, prot);
    exp_d = (!err && !wr) ? mregs[d][idx] : 32'd0;
    if (d == 0) exp_q0.push_back({err, exp_d});
    else        exp_q1.push_back({err, exp_d});
    psel_a[d] = 1'b1; pen_a[d] = 1'b0; pwr_a[d] = wr; paddr_a[d] = addr;
    pwdata_a[d] = dat; pstrb_a[d] = strb; pprot_a[d] = prot;
    @(negedge clk);
    pen_a[d] = 1'b1;
    n = 1; seen = 0;
    while (!seen && n <= 40) begin
      if (pready_a[d]) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk($sformatf("latency inst%0d", d), 32'(n), (d == 0) ? 32'd1 : 32'd4);
    if (!seen) begin
      if (d == 0) void'(exp_q0.pop_back());
      else        void'(exp_q1.pop_back());
    end
    @(negedge clk);
    if (!err && wr) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mregs[d][idx][b*8 +: 8] = dat[b*8 +: 8];
    end
  endtask

  task automatic release_bus(input int d);
    psel_a[d] = 1'b0;
    pen_a[d]  = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pready_a[i]) begin
        logic [32:0] e;
        bit          have;
        have = (i == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        tests++;
        if (prev_rdy[i]) begin
          fails++;
          $display("FAIL pready_width inst%0d: pready high on consecutive cycles, required one cycle", i);
        end
        if (!have) begin
          tests++; fails++;
          $display("FAIL unexpected_pready inst%0d: pready=1 with no transfer outstanding", i);
        end else begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("prdata inst%0d", i),  prdata_a[i],       e[31:0]);
          chk($sformatf("pslverr inst%0d", i), 32'(pslverr_a[i]), 32'(e[32]));
        end
      end
      prev_rdy[i] = pready_a[i];
    end
  end

  initial begin
    int d;
    bit b2b;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      psel_a[i] = 0; pen_a[i] = 0; pwr_a[i] = 0; paddr_a[i] = 0;
      pwdata_a[i] = 0; pstrb_a[i] = 0; pprot_a[i] = 0; prev_rdy[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_quiet(i, "reset");
      chk_regs(i);
    end

    // ID read, strobed write then read-back
    xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000);          release_bus(0);
    xfer(0, 1, 32'h4, 32'hDEADBEEF, 4'b0101, 3'b001); release_bus(0);
    chk_regs(0);
    xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'b000);          release_bus(0);
    chk("strobed value", mregs[0][1], 32'h00AD00EF);

    // three wait states
    xfer(1, 1, 32'h8, 32'h12345678, 4'hF, 3'b001);   release_bus(1);
    chk("regs_o[95:64] inst1", regs_a[1][95:64], 32'h12345678);

    // error cases
    xfer(0, 1, 32'h0,  32'hFFFFFFFF, 4'hF, 3'b001);  release_bus(0);
    xfer(0, 1, 32'h4,  32'hFFFFFFFF, 4'hF, 3'b000);  release_bus(0);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b001);         release_bus(0);
    xfer(0, 0, 32'h6,  32'h0, 4'h0, 3'b001);         release_bus(0);
    chk_regs(0);

    // back-to-back write then read, plus zero-strobe write
    xfer(0, 1, 32'hC, 32'hCAFEF00D, 4'hF, 3'b011);
    xfer(0, 0, 32'hC, 32'h0, 4'h0, 3'b000);
    xfer(0, 1, 32'hC, 32'h11111111, 4'h0, 3'b001);   release_bus(0);
    chk_regs(0);

    // pselx dropped during wait states
    psel_a[1] = 1; pen_a[1] = 0; pwr_a[1] = 1; paddr_a[1] = 32'h10;
    pwdata_a[1] = 32'hBAD0BAD0; pstrb_a[1] = 4'hF; pprot_a[1] = 3'b001;
    @(negedge clk); pen_a[1] = 1;
    @(negedge clk); psel_a[1] = 0; pen_a[1] = 0;
    repeat (5) @(negedge clk);
    chk_quiet(1, "abort");
    chk_regs(1);
    xfer(1, 0, 32'h8, 32'h0, 4'h0, 3'b000);          release_bus(1);

    // reset asserted during wait states
    psel_a[1] = 1; pen_a[1] = 0; pwr_a[1] = 1; paddr_a[1] = 32'h14;
    pwdata_a[1] = 32'h5A5A5A5A; pstrb_a[1] = 4'hF; pprot_a[1] = 3'b001;
    @(negedge clk); pen_a[1] = 1;
    @(negedge clk); rst = 1; psel_a[1] = 0; pen_a[1] = 0;
    @(negedge clk); rst = 0;
    model_reset();
    repeat (4) @(negedge clk);
    chk_quiet(1, "midreset");
    chk_regs(0);
    chk_regs(1);
    xfer(1, 1, 32'h14, 32'h0F0F0F0F, 4'hF, 3'b101);  release_bus(1);
    xfer(1, 0, 32'h14, 32'h0, 4'h0, 3'b000);         release_bus(1);

    // randomized traffic
    d = 0;
    b2b = 0;
    for (int it = 0; it < 120; it++) begin
      logic [31:0] addr;
      int          sel;
      if (!b2b) d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       addr = 32'(sel * 4);
      else if (sel == 8) addr = 32'($urandom_range(8, 64) * 4);
      else               addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      xfer(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)));
      chk_regs(d);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) release_bus(d);
    end
    release_bus(d);

    repeat (4) @(negedge clk);
    chk("leftover expectations inst0", 32'(exp_q0.size()), 32'd0);
    chk("leftover expectations inst1", 32'(exp_q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
